// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
//
// Execute-stage branch resolution. Evaluates conditional branches, JAL and
// JALR, computes the actual target and next PC, and compares the next PC
// with the one fetch predicted. Produces registered resolution, BTB-update
// and flush outputs. After a mispredict it squashes the wrong-path
// instructions already in flight, using a down-counter.
//
// Optional feature macro: BRU_PERF_CNT_EN
//   defined     -> perf_branches / perf_mispredicts are live 32-bit counters
//   not defined -> both ports tied to 0, no counter flops
//
// Parameters:
//   KILL_CYCLES           non-stalled cycles squashed after a mispredict (1-7)
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   stall                 freezes capture, kill counter and all outputs
//   in_valid, in_pc       instruction present / its PC
//   in_op                 branch opcode (non-branch codes never mispredict)
//   in_rs1, in_rs2        operand values
//   in_imm                sign-extended offset
//   in_pred_pc            next PC chosen by fetch
//   branch_taken_execute  pulse: resolved op was a taken branch or jump
//   pc_execute            PC of the resolved instruction
//   target_pc_execute     computed target, regardless of direction
//   flush                 pulse: mispredict, fetch must redirect
//   redirect_pc           correct next PC, valid while flush is high
//   link_value            in_pc+4 for JAL/JALR, 0 otherwise
//   squash                high while the kill counter is nonzero
//   perf_branches         branch-class capture count
//   perf_mispredicts      mispredict capture count
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int KILL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        in_valid,
    input  logic [31:0] in_pc,
    input  logic [3:0]  in_op,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic [31:0] in_imm,
    input  logic [31:0] in_pred_pc,
    output logic        branch_taken_execute,
    output logic [31:0] pc_execute,
    output logic [31:0] target_pc_execute,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic [31:0] link_value,
    output logic        squash,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_mispredicts
);

    // state | meaning
    // IDLE  | kill_cnt == 0, valid instructions are captured
    // KILL  | kill_cnt  > 0, incoming instructions are squashed
    typedef enum logic {
        IDLE = 1'b0,
        KILL = 1'b1
    } kill_state_t;

    localparam logic [2:0] KILL_LOAD = 3'(KILL_CYCLES);

    localparam logic [3:0] OP_JAL  = 4'b0010;
    localparam logic [3:0] OP_JALR = 4'b0011;
    localparam logic [3:0] OP_BEQ  = 4'b1000;
    localparam logic [3:0] OP_BNE  = 4'b1001;
    localparam logic [3:0] OP_BLT  = 4'b1100;
    localparam logic [3:0] OP_BGE  = 4'b1101;
    localparam logic [3:0] OP_BLTU = 4'b1110;
    localparam logic [3:0] OP_BGEU = 4'b1111;

    logic [2:0]  kill_cnt;
    logic [2:0]  kill_cnt_next;
    kill_state_t kill_state;

    logic        is_branch;
    logic        is_link;
    logic        taken;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic [31:0] actual_next;
    logic        mispredict;
    logic        capture;

    logic        taken_next;
    logic [31:0] pc_next;
    logic [31:0] target_next;
    logic        flush_next;
    logic [31:0] redirect_next;
    logic [31:0] link_next;

    assign kill_state = (kill_cnt != 3'd0) ? KILL : IDLE;
    assign squash     = (kill_state == KILL);

    // ------------------------------------------------------------------
    // Resolution datapath
    // ------------------------------------------------------------------
    assign pc_plus4 = in_pc + 32'd4;

    always_comb begin
        is_branch = 1'b1;
        is_link   = 1'b0;
        taken     = 1'b0;
        target    = in_pc + in_imm;
        case (in_op)
            OP_JAL: begin
                is_link = 1'b1;
                taken   = 1'b1;
            end
            OP_JALR: begin
                is_link = 1'b1;
                taken   = 1'b1;
                target  = (in_rs1 + in_imm) & 32'hFFFF_FFFE;
            end
            OP_BEQ:  taken = (in_rs1 == in_rs2);
            OP_BNE:  taken = (in_rs1 != in_rs2);
            OP_BLT:  taken = ($signed(in_rs1) <  $signed(in_rs2));
            OP_BGE:  taken = ($signed(in_rs1) >= $signed(in_rs2));
            OP_BLTU: taken = (in_rs1 <  in_rs2);
            OP_BGEU: taken = (in_rs1 >= in_rs2);
            default: is_branch = 1'b0;
        endcase
    end

    assign actual_next = taken ? target : pc_plus4;
    assign mispredict  = is_branch && (actual_next != in_pred_pc);
    assign capture     = in_valid && !stall && (kill_state == IDLE);

    // ------------------------------------------------------------------
    // Next-state / next-output logic. Everything holds by default, which
    // gives the stall behaviour; a non-stalled edge clears the pulses and
    // either counts down the kill window or captures.
    // ------------------------------------------------------------------
    always_comb begin
        kill_cnt_next = kill_cnt;
        taken_next    = branch_taken_execute;
        pc_next       = pc_execute;
        target_next   = target_pc_execute;
        flush_next    = flush;
        redirect_next = redirect_pc;
        link_next     = link_value;

        if (!stall) begin
            taken_next = 1'b0;
            flush_next = 1'b0;
            case (kill_state)
                KILL: kill_cnt_next = kill_cnt - 3'd1;
                IDLE: begin
                    if (in_valid) begin
                        taken_next  = is_branch && taken;
                        pc_next     = in_pc;
                        target_next = target;
                        link_next   = is_link ? pc_plus4 : 32'd0;
                        if (mispredict) begin
                            flush_next    = 1'b1;
                            redirect_next = actual_next;
                            kill_cnt_next = KILL_LOAD;
                        end
                    end
                end
                default: kill_cnt_next = 3'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            kill_cnt             <= 3'd0;
            branch_taken_execute <= 1'b0;
            pc_execute           <= 32'd0;
            target_pc_execute    <= 32'd0;
            flush                <= 1'b0;
            redirect_pc          <= 32'd0;
            link_value           <= 32'd0;
        end else begin
            kill_cnt             <= kill_cnt_next;
            branch_taken_execute <= taken_next;
            pc_execute           <= pc_next;
            target_pc_execute    <= target_next;
            flush                <= flush_next;
            redirect_pc          <= redirect_next;
            link_value           <= link_next;
        end
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef BRU_PERF_CNT_EN
    logic [31:0] perf_br_q;
    logic [31:0] perf_mp_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_br_q <= 32'd0;
            perf_mp_q <= 32'd0;
        end else if (capture) begin
            if (is_branch) begin
                perf_br_q <= perf_br_q + 32'd1;
            end
            if (mispredict) begin
                perf_mp_q <= perf_mp_q + 32'd1;
            end
        end
    end

    assign perf_branches    = perf_br_q;
    assign perf_mispredicts = perf_mp_q;
`else
    assign perf_branches    = 32'd0;
    assign perf_mispredicts = 32'd0;

    // capture only feeds the counters; keep it referenced in this build
    logic unused_capture;
    assign unused_capture = capture;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

    localparam int KILL = 2;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [3:0]  in_op;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [31:0] in_imm;
    logic [31:0] in_pred_pc;
    logic        branch_taken_execute;
    logic [31:0] pc_execute;
    logic [31:0] target_pc_execute;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [31:0] link_value;
    logic        squash;
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;

    branch_resolve_unit #(.KILL_CYCLES(KILL)) dut (
        .clk                  (clk),
        .reset                (reset),
        .stall                (stall),
        .in_valid             (in_valid),
        .in_pc                (in_pc),
        .in_op                (in_op),
        .in_rs1               (in_rs1),
        .in_rs2               (in_rs2),
        .in_imm               (in_imm),
        .in_pred_pc           (in_pred_pc),
        .branch_taken_execute (branch_taken_execute),
        .pc_execute           (pc_execute),
        .target_pc_execute    (target_pc_execute),
        .flush                (flush),
        .redirect_pc          (redirect_pc),
        .link_value           (link_value),
        .squash               (squash),
        .perf_branches        (perf_branches),
        .perf_mispredicts     (perf_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        br;
        logic        taken;
        logic [31:0] pc;
        logic [31:0] target;
        logic        flush;
        logic [31:0] redir;
        logic [31:0] link;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    int          mk;
    logic [31:0] pb;
    logic [31:0] pm;
    int          errors;
    int          checks;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic exp_t resolve(input logic [3:0] op, input logic [31:0] pc,
                                     input logic [31:0] rs1, input logic [31:0] rs2,
                                     input logic [31:0] imm, input logic [31:0] pred);
        exp_t        e;
        logic        tk;
        logic [31:0] tgt;
        logic [31:0] nxt;
        e    = '0;
        e.br = 1'b1;
        tk   = 1'b0;
        tgt  = pc + imm;
        case (op)
            4'b0010: tk = 1'b1;
            4'b0011: begin tk = 1'b1; tgt = (rs1 + imm) & 32'hFFFF_FFFE; end
            4'b1000: tk = (rs1 == rs2);
            4'b1001: tk = (rs1 != rs2);
            4'b1100: tk = ($signed(rs1) <  $signed(rs2));
            4'b1101: tk = ($signed(rs1) >= $signed(rs2));
            4'b1110: tk = (rs1 <  rs2);
            4'b1111: tk = (rs1 >= rs2);
            default: e.br = 1'b0;
        endcase
        nxt      = tk ? tgt : pc + 32'd4;
        e.taken  = e.br && tk;
        e.pc     = pc;
        e.target = tgt;
        e.flush  = e.br && (nxt != pred);
        e.redir  = nxt;
        e.link   = (op == 4'b0010 || op == 4'b0011) ? pc + 32'd4 : 32'd0;
        return e;
    endfunction

    // One clock edge: drive, advance the model, push expected captures,
    // then pop and compare every output after the edge.
    task automatic step(input logic r, input logic v, input logic st, input logic [3:0] op,
                        input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] imm, input logic [31:0] pred);
        exp_t e;
        reset      = r;
        stall      = st;
        in_valid   = v;
        in_op      = op;
        in_pc      = pc;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_imm     = imm;
        in_pred_pc = pred;
        if (r) begin
            cur = '0;
            mk  = 0;
            pb  = '0;
            pm  = '0;
            sb.delete();
        end else if (!st) begin
            cur.taken = 1'b0;
            cur.flush = 1'b0;
            if (mk != 0) begin
                mk--;
            end else if (v) begin
                e = resolve(op, pc, rs1, rs2, imm, pred);
                sb.push_back(e);
                if (e.br) pb++;
                if (e.flush) begin
                    pm++;
                    mk = KILL;
                end
            end
        end
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        if (sb.size() > 0) begin
            e          = sb.pop_front();
            cur.taken  = e.taken;
            cur.pc     = e.pc;
            cur.target = e.target;
            cur.link   = e.link;
            if (e.flush) begin
                cur.flush = 1'b1;
                cur.redir = e.redir;
            end
        end
        check_eq("taken",    {31'd0, branch_taken_execute}, {31'd0, cur.taken});
        check_eq("pc",       pc_execute,        cur.pc);
        check_eq("target",   target_pc_execute, cur.target);
        check_eq("flush",    {31'd0, flush},    {31'd0, cur.flush});
        check_eq("redirect", redirect_pc,       cur.redir);
        check_eq("link",     link_value,        cur.link);
        check_eq("squash",   {31'd0, squash},   {31'd0, mk != 0});
`ifdef BRU_PERF_CNT_EN
        check_eq("perf_br",  perf_branches,    pb);
        check_eq("perf_mp",  perf_mispredicts, pm);
`else
        check_eq("perf_br_off", perf_branches,    32'd0);
        check_eq("perf_mp_off", perf_mispredicts, 32'd0);
`endif
    endtask

    task automatic br(input logic [3:0] op, input logic [31:0] pc, input logic [31:0] rs1,
                      input logic [31:0] rs2, input logic [31:0] imm, input logic [31:0] pred);
        step(1'b0, 1'b1, 1'b0, op, pc, rs1, rs2, imm, pred);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 4'b0000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    endtask

    initial begin
        logic [3:0]  ops [10];
        logic [3:0]  op;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] pred;
        exp_t        e;

        ops = '{4'b0000, 4'b0010, 4'b0011, 4'b1000, 4'b1001,
                4'b1100, 4'b1101, 4'b1110, 4'b1111, 4'b0101};
        errors = 0;
        checks = 0;
        cur = '0;
        mk  = 0;
        pb  = '0;
        pm  = '0;

        step(1'b1, 1'b0, 1'b0, 4'b0000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        step(1'b1, 1'b1, 1'b0, 4'b0010, 32'h40, 32'd0, 32'd0, 32'd8, 32'd0);

        // BEQ taken, correctly predicted
        br(4'b1000, 32'h100, 32'd5, 32'd5, 32'h20, 32'h120);
        check_eq("tp_beq_taken",  {31'd0, branch_taken_execute}, 32'd1);
        check_eq("tp_beq_target", target_pc_execute, 32'h120);
        check_eq("tp_beq_flush",  {31'd0, flush}, 32'd0);

        // BNE not taken, predicted taken -> flush, then two squashed edges
        br(4'b1001, 32'h200, 32'd7, 32'd7, 32'h40, 32'h240);
        check_eq("tp_bne_flush", {31'd0, flush}, 32'd1);
        check_eq("tp_bne_redir", redirect_pc, 32'h204);
        check_eq("tp_bne_sq0",   {31'd0, squash}, 32'd1);
        br(4'b0010, 32'h900, 32'd0, 32'd0, 32'h10, 32'h0);
        check_eq("tp_bne_sq1",   {31'd0, squash}, 32'd1);
        check_eq("tp_bne_drop1", pc_execute, 32'h200);
        br(4'b0010, 32'h910, 32'd0, 32'd0, 32'h10, 32'h0);
        check_eq("tp_bne_sq2",   {31'd0, squash}, 32'd0);
        check_eq("tp_bne_drop2", pc_execute, 32'h200);

        // JALR with odd base: target bit 0 cleared
        br(4'b0011, 32'h300, 32'h1001, 32'd0, 32'h10, 32'h304);
        check_eq("tp_jalr_redir", redirect_pc, 32'h1010);
        check_eq("tp_jalr_link",  link_value,  32'h304);
        idle();
        idle();

        // Signed versus unsigned compare on the same operands
        br(4'b1100, 32'h400, 32'hFFFF_FFFF, 32'd1, 32'h8, 32'h408);
        check_eq("tp_blt_taken",  {31'd0, branch_taken_execute}, 32'd1);
        br(4'b1110, 32'h500, 32'hFFFF_FFFF, 32'd1, 32'h8, 32'h504);
        check_eq("tp_bltu_taken", {31'd0, branch_taken_execute}, 32'd0);

        // Back-to-back correct predictions, non-branch and unknown ops
        br(4'b0010, 32'h600, 32'd0, 32'd0, 32'hFFFF_FF00, 32'h500);
        br(4'b1101, 32'h604, 32'h8000_0000, 32'd0, 32'h20, 32'h608);
        br(4'b1111, 32'h608, 32'h8000_0000, 32'd0, 32'h20, 32'h628);
        br(4'b0000, 32'h60C, 32'd0, 32'd0, 32'h40, 32'hDEAD);
        check_eq("nonbr_flush", {31'd0, flush}, 32'd0);
        br(4'b0101, 32'h610, 32'd0, 32'd0, 32'h40, 32'hBEEF);
        check_eq("unk_flush", {31'd0, flush}, 32'd0);

        // Mispredict then 3 stalled edges: everything holds
        br(4'b1000, 32'h700, 32'd1, 32'd1, 32'h10, 32'h704);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b1, 4'b0010, 32'h800, 32'd0, 32'd0, 32'h4, 32'h0);
            check_eq("stall_flush", {31'd0, flush}, 32'd1);
            check_eq("stall_redir", redirect_pc, 32'h710);
        end
        idle();
        check_eq("stall_rel_sq", {31'd0, squash}, 32'd1);
        idle();
        check_eq("stall_end_sq", {31'd0, squash}, 32'd0);

        // Reset mid-kill
        br(4'b1001, 32'hA00, 32'd1, 32'd2, 32'h80, 32'hA04);
        idle();
        step(1'b1, 1'b1, 1'b0, 4'b0010, 32'hB00, 32'd0, 32'd0, 32'h4, 32'h0);
        check_eq("rst_squash", {31'd0, squash}, 32'd0);
        check_eq("rst_redir",  redirect_pc, 32'd0);
        check_eq("rst_pc",     pc_execute, 32'd0);

        // Four branches, one mispredict
        br(4'b1000, 32'hC00, 32'd3, 32'd3, 32'h10, 32'hC10);
        br(4'b0010, 32'hC10, 32'd0, 32'd0, 32'h20, 32'hC30);
        br(4'b1001, 32'hC30, 32'd1, 32'd2, 32'h10, 32'hC40);
        br(4'b1110, 32'hC40, 32'd9, 32'd2, 32'h10, 32'hC50);
        idle();
        idle();
`ifdef BRU_PERF_CNT_EN
        check_eq("tp_perf_br", perf_branches,    32'd4);
        check_eq("tp_perf_mp", perf_mispredicts, 32'd1);
`endif

        // Randomised mix with stalls and idle gaps
        for (int i = 0; i < 60; i++) begin
            op  = ops[$urandom_range(0, 9)];
            pc  = $urandom() & 32'hFFFF_FFFC;
            rs1 = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom();
            rs2 = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom();
            imm = 32'($signed(12'($urandom_range(0, 4095))));
            e   = resolve(op, pc, rs1, rs2, imm, 32'd0);
            pred = ($urandom_range(0, 2) != 0) ? e.redir : $urandom();
            step(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                 op, pc, rs1, rs2, imm, pred);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
